btn_debounce_bank: RTL and testbench

- Conditions the five raw Basys3 push-buttons (btnC/U/L/R/D) before they reach the student feature modules.
- Per button: 2-flop synchronizer, counter-based debounce FSM, registered stable level, and single-cycle press/release pulses in the clock_100mhz domain.
- Sits directly upstream of the student modules, which consume clean pulses instead of raw bouncing inputs.

---
 rtl/btn_debounce_bank.sv | 199 +++++++++++++++++++
 tb/tb_btn_debounce_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_bank.sv
// Five-channel push-button conditioner: 2-flop synchronizer, re-registered sync output,
// then a per-channel counter-based debounce FSM. Optional auto-repeat under `BTN_AUTO_REPEAT_EN.
// Latency: DEBOUNCE_CYCLES+3 edges from first sample to level/pulse; no backpressure (pulses are fire-and-forget).
module btn_debounce_bank #(
    parameter int NUM_BTN              = 5,
    parameter int DEBOUNCE_CYCLES      = 2000000,
    parameter int CNT_W                = 32,
    parameter int REPEAT_DELAY_CYCLES  = 50000000,
    parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
    input  logic               clock_100mhz,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    localparam int CNT_MAX_I =
        (DEBOUNCE_CYCLES >= REPEAT_DELAY_CYCLES && DEBOUNCE_CYCLES >= REPEAT_PERIOD_CYCLES) ? DEBOUNCE_CYCLES :
        (REPEAT_DELAY_CYCLES >= REPEAT_PERIOD_CYCLES) ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_MAX_I);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
`endif

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] s_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_d;
    logic [NUM_BTN-1:0] release_d;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] release_q;

    // s_q re-times the synchronizer output so the FSM compare starts from a clean flop.
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            s_q     <= sync2_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] cnt_inc;
        logic             s;
        logic             ch_press;
        logic             ch_release;
`ifdef BTN_AUTO_REPEAT_EN
        logic             rpt_armed_q;
        logic             rpt_armed_d;
`endif

        assign s = s_q[i];
        // Saturating increment keeps the counter from ever wrapping.
        assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            ch_press   = 1'b0;
            ch_release = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_armed_d = rpt_armed_q;
`endif
            case (state_q)
                ST_LOW: begin
                    cnt_d = CNT_ZERO;
                    if (s) begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s) begin
                        state_d = ST_LOW;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d  = ST_HIGH;
                        cnt_d    = CNT_ZERO;
                        ch_press = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                        rpt_armed_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = CNT_ZERO;
`ifdef BTN_AUTO_REPEAT_EN
                    end else if (!rpt_armed_q) begin
                        if (cnt_q == RPT_DELAY_LAST) begin
                            ch_press    = 1'b1;
                            cnt_d       = CNT_ZERO;
                            rpt_armed_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        if (cnt_q == RPT_PERIOD_LAST) begin
                            ch_press = 1'b1;
                            cnt_d    = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
`else
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
`endif
                end
                ST_WAIT_LOW: begin
                    if (s) begin
                        // Bounce back to HIGH: no pulse, and any repeat delay starts over.
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ZERO;
`ifdef BTN_AUTO_REPEAT_EN
                        rpt_armed_d = 1'b0;
`endif
                    end else if (cnt_q == DEB_LAST) begin
                        state_d    = ST_LOW;
                        cnt_d      = CNT_ZERO;
                        ch_release = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        always_ff @(posedge clock_100mhz or posedge reset) begin
            if (reset) begin
                state_q <= ST_LOW;
                cnt_q   <= CNT_ZERO;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

`ifdef BTN_AUTO_REPEAT_EN
        always_ff @(posedge clock_100mhz or posedge reset) begin
            if (reset) begin
                rpt_armed_q <= 1'b0;
            end else begin
                rpt_armed_q <= rpt_armed_d;
            end
        end
`endif

        assign level_d[i]   = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
        assign press_d[i]   = ch_press;
        assign release_d[i] = ch_release;
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Scoreboard bench for btn_debounce_bank: stimulus pushes expected pulse events, a monitor pops and compares.
module tb_btn_debounce_bank;

    logic       clock_100mhz = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int         at;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] lvl;
    } exp_t;

    exp_t exp_q[$];

    btn_debounce_bank #(
        .NUM_BTN(5),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(8),
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_PERIOD_CYCLES(5)
    ) dut (
        .clock_100mhz(clock_100mhz),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 clock_100mhz = ~clock_100mhz;
    always @(posedge clock_100mhz) cyc <= cyc + 1;

    task automatic expect_evt(input int at, input logic [4:0] p, input logic [4:0] r, input logic [4:0] l);
        exp_t e;
        e.at = at; e.press = p; e.rel = r; e.lvl = l;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock_100mhz);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock_100mhz);
    endtask

    // Monitor: any pulse must match the head of the queue exactly, in cycle and content.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock_100mhz);
            if (btn_press !== 5'b0 || btn_release !== 5'b0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: press=%b release=%b level=%b at cycle %0d",
                             btn_press, btn_release, btn_level, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at != cyc || btn_press !== e.press || btn_release !== e.rel || btn_level !== e.lvl) begin
                        fails++;
                        $display("FAIL pulse_event: cycle=%0d press=%b release=%b level=%b required cycle=%0d press=%b release=%b level=%b",
                                 cyc, btn_press, btn_release, btn_level, e.at, e.press, e.rel, e.lvl);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_pulse: nothing seen by cycle %0d, required press=%b release=%b at cycle %0d",
                         cyc, e.press, e.rel, e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset   = 1'b1;
        btn_raw = 5'b0;
        hold(3);
        check("reset_state", {btn_level, btn_press, btn_release}, 15'b0);
        reset = 1'b0;

        // Clean press on btnC.
        hold(1);
        btn_raw = 5'b00001; t = cyc;
        expect_evt(t + 12, 5'b00001, 5'b0, 5'b00001);
        wait_until(t + 20);
        check("clean_press_level", {10'b0, btn_level}, {10'b0, 5'b00001});

        // Async reset mid-cycle with every button held; held buttons re-press after reset.
        btn_raw = 5'b11111;
        #2 reset = 1'b1;
        #1 check("async_reset_clear", {btn_level, btn_press, btn_release}, 15'b0);
        hold(1);
        reset = 1'b0; t = cyc;
        expect_evt(t + 12, 5'b11111, 5'b0, 5'b11111);
        wait_until(t + 20);

        btn_raw = 5'b0; t = cyc;
        expect_evt(t + 12, 5'b0, 5'b11111, 5'b0);
        wait_until(t + 20);

        // Bounce on btnL: 3-cycle segments then a steady rise.
        btn_raw = 5'b00100; hold(3);
        btn_raw = 5'b00000; hold(3);
        btn_raw = 5'b00100; hold(3);
        btn_raw = 5'b00000; hold(3);
        check("bounce_no_level", {10'b0, btn_level}, 15'b0);
        btn_raw = 5'b00100; t = cyc;
        expect_evt(t + 12, 5'b00100, 5'b0, 5'b00100);
        wait_until(t + 20);

        // Release of btnC preceded by a 5-cycle low glitch.
        btn_raw = 5'b00101; t = cyc;
        expect_evt(t + 12, 5'b00001, 5'b0, 5'b00101);
        wait_until(t + 20);
        btn_raw = 5'b00100; hold(5);
        btn_raw = 5'b00101; hold(5);
        check("glitch_keeps_level", {10'b0, btn_level}, {10'b0, 5'b00101});
        btn_raw = 5'b00100; t = cyc;
        expect_evt(t + 12, 5'b0, 5'b00001, 5'b00100);
        wait_until(t + 20);

        btn_raw = 5'b0; t = cyc;
        expect_evt(t + 12, 5'b0, 5'b00100, 5'b0);
        wait_until(t + 20);

        // btnU and btnD rise together; btnU drops after 4 cycles.
        btn_raw = 5'b10010; t = cyc;
        expect_evt(t + 12, 5'b10000, 5'b0, 5'b10000);
        hold(4);
        btn_raw = 5'b10000;
        wait_until(t + 20);
        check("simul_level", {10'b0, btn_level}, {10'b0, 5'b10000});

        btn_raw = 5'b0; t = cyc;
        expect_evt(t + 12, 5'b0, 5'b10000, 5'b0);
        wait_until(t + 20);

        // btnR held 50 cycles.
        btn_raw = 5'b01000; t = cyc;
        expect_evt(t + 12, 5'b01000, 5'b0, 5'b01000);
`ifdef BTN_AUTO_REPEAT_EN
        for (int k = 0; k < 5; k++) begin
            expect_evt(t + 32 + 5 * k, 5'b01000, 5'b0, 5'b01000);
        end
`endif
        wait_until(t + 50);
        btn_raw = 5'b0;
        expect_evt(t + 62, 5'b0, 5'b01000, 5'b0);
        wait_until(t + 75);

        check("final_level", {10'b0, btn_level}, 15'b0);
        check("scoreboard_drained", 15'(exp_q.size()), 15'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
